// File: rtl/serdes_frame_ctrl.sv
// serdes_frame_ctrl
// Frame-level transmit sequencer for the AXI-to-SERDES direction of fifo_serdes (clk_fast domain).
// Streams FRAME_LEN words out of the FIFO, waits for the far end's CRC verdict, then
// commits the frame (ACK) or rewinds the FIFO read pointer for a retransmission (NACK/timeout).
// After MAX_RETRY retransmissions the frame is abandoned and discarded.
//
// Ports:
//   clk_fast          - single clock, rising edge
//   reset             - synchronous, active-high
//   start_i           - request to send one frame (sampled in IDLE only)
//   fifo_empty_ctrl_i - FIFO empty flag, SERDES side
//   rd_en_fast_o      - FIFO read enable (combinational in SEND)
//   frame_last_o      - qualifies the final word of the frame
//   ack_i / nack_i    - far-end CRC verdict pulses (looked at in WAIT_ACK only)
//   fifo_command_o    - 0 idle, 1 commit/discard, 2 rewind
//   busy_o            - high outside IDLE
//   frame_done_o      - one-cycle pulse on commit after ACK
//   frame_fail_o      - one-cycle pulse when the frame is abandoned
//   retry_cnt_o       - retransmissions of the current frame
module serdes_frame_ctrl #(
    parameter int unsigned FRAME_LEN   = 8,
    parameter int unsigned ACK_TIMEOUT = 64,
    parameter int unsigned MAX_RETRY   = 3,
    // Bits needed to hold the value itself (clogb2 semantics), so retry can reach MAX_RETRY.
    localparam int unsigned CW = $clog2(FRAME_LEN + 1),
    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1),
    localparam int unsigned RW = $clog2(MAX_RETRY + 1)
) (
    input  logic          clk_fast,
    input  logic          reset,
    input  logic          start_i,
    input  logic          fifo_empty_ctrl_i,
    output logic          rd_en_fast_o,
    output logic          frame_last_o,
    input  logic          ack_i,
    input  logic          nack_i,
    output logic [3:0]    fifo_command_o,
    output logic          busy_o,
    output logic          frame_done_o,
    output logic          frame_fail_o,
    output logic [RW-1:0] retry_cnt_o
);

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StWaitAck,
        StCommit,
        StRewind,
        StFail
    } state_e;

    localparam logic [3:0] CmdIdle   = 4'd0;
    localparam logic [3:0] CmdCommit = 4'd1;
    localparam logic [3:0] CmdRewind = 4'd2;

    localparam logic [CW-1:0] LastWord  = CW'(FRAME_LEN - 1);
    localparam logic [TW-1:0] LastTick  = TW'(ACK_TIMEOUT - 1);
    localparam logic [RW-1:0] RetryMax  = RW'(MAX_RETRY);

    state_e        state_q, state_d;
    logic [CW-1:0] word_cnt_q, word_cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          bad_verdict;

    always_ff @(posedge clk_fast) begin
        if (reset) begin
            state_q    <= StIdle;
            word_cnt_q <= '0;
            timer_q    <= '0;
            retry_q    <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            timer_q    <= timer_d;
            retry_q    <= retry_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        word_cnt_d     = word_cnt_q;
        timer_d        = timer_q;
        retry_d        = retry_q;
        bad_verdict    = 1'b0;
        rd_en_fast_o   = 1'b0;
        frame_last_o   = 1'b0;
        fifo_command_o = CmdIdle;
        frame_done_o   = 1'b0;
        frame_fail_o   = 1'b0;
        busy_o         = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                // Accepted even with an empty FIFO; SEND simply stalls.
                if (start_i) begin
                    state_d    = StSend;
                    word_cnt_d = '0;
                end
            end
            StSend: begin
                rd_en_fast_o = !fifo_empty_ctrl_i;
                if (rd_en_fast_o) begin
                    word_cnt_d = word_cnt_q + CW'(1);
                    if (word_cnt_q == LastWord) begin
                        frame_last_o = 1'b1;
                        state_d      = StWaitAck;
                        timer_d      = '0;
                    end
                end
            end
            StWaitAck: begin
                timer_d = timer_q + TW'(1);
                // NACK beats a simultaneous ACK; ACK on the last tick still counts.
                bad_verdict = nack_i || ((timer_q == LastTick) && !ack_i);
                if (bad_verdict) begin
                    state_d = (retry_q == RetryMax) ? StFail : StRewind;
                end else if (ack_i) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                fifo_command_o = CmdCommit;
                frame_done_o   = 1'b1;
                retry_d        = '0;
                state_d        = StIdle;
            end
            StRewind: begin
                // Read is idle here, so the FIFO can restore its pointer at the end of this cycle.
                fifo_command_o = CmdRewind;
                retry_d        = retry_q + RW'(1);
                word_cnt_d     = '0;
                state_d        = StSend;
            end
            StFail: begin
                // Commit doubles as discard so the abandoned frame frees FIFO space.
                fifo_command_o = CmdCommit;
                frame_fail_o   = 1'b1;
                retry_d        = '0;
                state_d        = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_serdes_frame_ctrl.sv
module tb_serdes_frame_ctrl;

    localparam int unsigned FL  = 4;
    localparam int unsigned TO  = 8;
    localparam int unsigned MR  = 2;
    localparam int unsigned RWB = 2;

    logic           clk_fast = 1'b0;
    logic           reset;
    logic           start_i;
    logic           fifo_empty_ctrl_i;
    logic           rd_en_fast_o;
    logic           frame_last_o;
    logic           ack_i;
    logic           nack_i;
    logic [3:0]     fifo_command_o;
    logic           busy_o;
    logic           frame_done_o;
    logic           frame_fail_o;
    logic [RWB-1:0] retry_cnt_o;

    always #5 clk_fast = ~clk_fast;

    serdes_frame_ctrl #(
        .FRAME_LEN  (FL),
        .ACK_TIMEOUT(TO),
        .MAX_RETRY  (MR)
    ) dut (
        .clk_fast         (clk_fast),
        .reset            (reset),
        .start_i          (start_i),
        .fifo_empty_ctrl_i(fifo_empty_ctrl_i),
        .rd_en_fast_o     (rd_en_fast_o),
        .frame_last_o     (frame_last_o),
        .ack_i            (ack_i),
        .nack_i           (nack_i),
        .fifo_command_o   (fifo_command_o),
        .busy_o           (busy_o),
        .frame_done_o     (frame_done_o),
        .frame_fail_o     (frame_fail_o),
        .retry_cnt_o      (retry_cnt_o)
    );

    typedef struct {
        logic           rst, start, empty, ack, nack;
        logic           rd, last;
        logic [3:0]     cmd;
        logic           busy, done, fail;
        logic [RWB-1:0] retry;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic rst, start, empty, ack, nack, rd, last,
                       input logic [3:0] cmd, input logic busy, done, fail,
                       input logic [RWB-1:0] r);
        vec_t v;
        v.rst = rst; v.start = start; v.empty = empty; v.ack = ack; v.nack = nack;
        v.rd = rd; v.last = last; v.cmd = cmd; v.busy = busy; v.done = done;
        v.fail = fail; v.retry = r;
        vecs.push_back(v);
    endtask

    task automatic idle_v(input logic start, empty, ack, nack);
        add(1'b0, start, empty, ack, nack, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic send_words(input int first, input int n, input logic [RWB-1:0] r);
        for (int i = first; i < first + n; i++)
            add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, (i == FL - 1), 4'd0, 1'b1, 1'b0, 1'b0, r);
    endtask

    task automatic wait_v(input int n, input logic ack, nack, input logic [RWB-1:0] r);
        for (int i = 0; i < n; i++)
            add(1'b0, 1'b0, 1'b0, ack, nack, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, r);
    endtask

    task automatic rewind_v(input logic [RWB-1:0] r);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0, r);
    endtask

    task automatic commit_v(input logic [RWB-1:0] r);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0, r);
    endtask

    task automatic fail_v(input logic [RWB-1:0] r);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b1, r);
    endtask

    task automatic drive(input vec_t v);
        reset             = v.rst;
        start_i           = v.start;
        fifo_empty_ctrl_i = v.empty;
        ack_i             = v.ack;
        nack_i            = v.nack;
    endtask

    task automatic compare(input vec_t e, input int idx);
        chk("rd_en",   idx, 32'(rd_en_fast_o),  32'(e.rd));
        chk("last",    idx, 32'(frame_last_o),  32'(e.last));
        chk("command", idx, 32'(fifo_command_o), 32'(e.cmd));
        chk("busy",    idx, 32'(busy_o),        32'(e.busy));
        chk("done",    idx, 32'(frame_done_o),  32'(e.done));
        chk("fail",    idx, 32'(frame_fail_o),  32'(e.fail));
        chk("retry",   idx, 32'(retry_cnt_o),   32'(e.retry));
    endtask

    initial begin
        int   cycles;
        int   rewinds;
        logic seen_fail;
        vec_t e;

        // Clean frame, ACK 3 cycles after the last word; stray ACK/NACK in IDLE ignored.
        idle_v(1'b1, 1'b0, 1'b0, 1'b0);
        send_words(0, FL, 2'd0);
        wait_v(2, 1'b0, 1'b0, 2'd0);
        wait_v(1, 1'b1, 1'b0, 2'd0);
        commit_v(2'd0);
        idle_v(1'b0, 1'b0, 1'b1, 1'b0);
        idle_v(1'b0, 1'b0, 1'b0, 1'b1);
        idle_v(1'b0, 1'b0, 1'b0, 1'b0);

        // Single NACK in the first WAIT_ACK cycle, then ACK.
        idle_v(1'b1, 1'b0, 1'b0, 1'b0);
        send_words(0, FL, 2'd0);
        wait_v(1, 1'b0, 1'b1, 2'd0);
        rewind_v(2'd0);
        send_words(0, FL, 2'd1);
        wait_v(1, 1'b1, 1'b0, 2'd1);
        commit_v(2'd1);
        idle_v(1'b0, 1'b0, 1'b0, 1'b0);

        // ACK+NACK during SEND ignored; ACK+NACK together in WAIT_ACK rewinds.
        idle_v(1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        send_words(1, FL - 1, 2'd0);
        wait_v(1, 1'b1, 1'b1, 2'd0);
        rewind_v(2'd0);
        send_words(0, FL, 2'd1);
        wait_v(1, 1'b1, 1'b0, 2'd1);
        commit_v(2'd1);
        idle_v(1'b0, 1'b0, 1'b0, 1'b0);

        // Timeout exhaustion: three transmissions, each followed by TO silent cycles.
        idle_v(1'b1, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r <= int'(MR); r++) begin
            send_words(0, FL, RWB'(r));
            wait_v(TO, 1'b0, 1'b0, RWB'(r));
            if (r < int'(MR)) rewind_v(RWB'(r));
            else fail_v(RWB'(r));
        end
        idle_v(1'b0, 1'b0, 1'b0, 1'b0);

        // ACK on the very last WAIT_ACK tick still commits.
        idle_v(1'b1, 1'b0, 1'b0, 1'b0);
        send_words(0, FL, 2'd0);
        wait_v(TO - 1, 1'b0, 1'b0, 2'd0);
        wait_v(1, 1'b1, 1'b0, 2'd0);
        commit_v(2'd0);
        idle_v(1'b0, 1'b0, 1'b0, 1'b0);

        // Start with an empty FIFO, two words, a stall longer than ACK_TIMEOUT, two more words.
        idle_v(1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        send_words(0, 2, 2'd0);
        for (int i = 0; i < 10; i++)
            add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        send_words(2, 2, 2'd0);
        wait_v(1, 1'b1, 1'b0, 2'd0);
        commit_v(2'd0);
        idle_v(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset during a retransmission after 2 reads; fresh start begins at word 0.
        idle_v(1'b1, 1'b0, 1'b0, 1'b0);
        send_words(0, FL, 2'd0);
        wait_v(1, 1'b0, 1'b1, 2'd0);
        rewind_v(2'd0);
        send_words(0, 2, 2'd1);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 2'd1);
        idle_v(1'b0, 1'b0, 1'b0, 1'b0);
        idle_v(1'b1, 1'b0, 1'b0, 1'b0);
        send_words(0, FL, 2'd0);
        wait_v(1, 1'b1, 1'b0, 2'd0);
        commit_v(2'd0);
        idle_v(1'b0, 1'b0, 1'b0, 1'b0);

        // Power-on reset.
        reset = 1'b1; start_i = 1'b0; fifo_empty_ctrl_i = 1'b0; ack_i = 1'b0; nack_i = 1'b0;
        @(posedge clk_fast); #1;
        @(negedge clk_fast);
        chk("reset_busy",    -1, 32'(busy_o),         32'd0);
        chk("reset_rd_en",   -1, 32'(rd_en_fast_o),   32'd0);
        chk("reset_command", -1, 32'(fifo_command_o), 32'd0);
        chk("reset_retry",   -1, 32'(retry_cnt_o),    32'd0);

        // Table: expected record pushed when stimulus is driven, popped at the sample point.
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk_fast); #1;
            drive(vecs[i]);
            sb.push_back(vecs[i]);
            @(negedge clk_fast);
            e = sb.pop_front();
            compare(e, i);
        end

        // Worst-case frame lifetime: start cycle through the FAIL cycle inclusive.
        @(posedge clk_fast); #1;
        reset = 1'b0; start_i = 1'b1; fifo_empty_ctrl_i = 1'b0; ack_i = 1'b0; nack_i = 1'b0;
        @(negedge clk_fast);
        cycles = 1; rewinds = 0; seen_fail = 1'b0;
        @(posedge clk_fast); #1;
        start_i = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk_fast);
            cycles++;
            if (fifo_command_o == 4'd2) rewinds++;
            if (frame_fail_o) begin
                seen_fail = 1'b1;
                chk("fail_command", k, 32'(fifo_command_o), 32'd1);
                break;
            end
        end
        chk("fail_seen", -1, 32'(seen_fail), 32'd1);
        chk("lifetime",  -1, 32'(cycles), 32'((MR + 1) * (FL + TO + 1) + 1));
        chk("rewinds",   -1, 32'(rewinds), 32'(MR));
        @(negedge clk_fast);
        chk("idle_after_fail", -1, 32'(busy_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serdes_frame_ctrl.md
# serdes_frame_ctrl

Frame-level transmit sequencer for the AXI-to-SERDES direction of `fifo_serdes`, in the `clk_fast` domain.
- Reads `FRAME_LEN` words from the FIFO towards the SERDES and waits for the far end's CRC verdict.
- Drives `fifo_command_i`: commit (1) on ACK; rewind (2) on NACK or timeout.
- Abandons the frame after `MAX_RETRY` retransmissions.

## Interface
Parameters:
- `FRAME_LEN`, 8 — words per frame, ≥2.
- `ACK_TIMEOUT`, 64 — cycles in WAIT_ACK before an implicit NACK, ≥2.
- `MAX_RETRY`, 3 — retransmissions allowed before abandoning, ≥1.

Widths: `CW` = clogb2(`FRAME_LEN`), `TW` = clogb2(`ACK_TIMEOUT`), `RW` = clogb2(`MAX_RETRY`).

Ports:
- `clk_fast` in 1 — single clock; all logic on its rising edge.
- `reset` in 1 — synchronous, active-high.
- `start_i` in 1 — request to send one frame; sampled in IDLE only.
- `fifo_empty_ctrl_i` in 1 — FIFO empty flag, SERDES side.
- `rd_en_fast_o` out 1 — FIFO read enable; `data_o` is valid in the same cycle.
- `frame_last_o` out 1 — qualifies the final word of the frame.
- `ack_i` in 1 — far end reports CRC good; single-cycle pulse.
- `nack_i` in 1 — far end reports CRC bad; single-cycle pulse.
- `fifo_command_o` out 4 — 0 idle, 1 commit/discard, 2 rewind; to `fifo_command_i`.
- `busy_o` out 1 — high in any state other than IDLE.
- `frame_done_o` out 1 — one-cycle pulse when a frame is committed after ACK.
- `frame_fail_o` out 1 — one-cycle pulse when a frame is abandoned.
- `retry_cnt_o` out `RW` — retransmissions of the current frame.

## Operation
States: IDLE, SEND, WAIT_ACK, COMMIT, REWIND, FAIL. Internal counters: `word_cnt` (`CW` bits), `timer` (`TW` bits), `retry` (`RW` bits).

- **IDLE**
  - `start_i` → SEND with `word_cnt`=0.
  - `start_i` is accepted even if the FIFO is empty; SEND then stalls.
- **SEND**
  - `rd_en_fast_o` = !`fifo_empty_ctrl_i` (combinational). It is 0 in every other state.
  - Each cycle with `rd_en_fast_o`=1, `word_cnt` increments.
  - `frame_last_o` = `rd_en_fast_o` && `word_cnt`==`FRAME_LEN`-1.
  - The cycle with `frame_last_o` → WAIT_ACK with `timer`=0.
  - Empty mid-frame: stall, hold `word_cnt`. SEND has no timeout.
- **WAIT_ACK**
  - `timer` increments every cycle.
  - `nack_i`, or `timer`==`ACK_TIMEOUT`-1 without `ack_i` → bad verdict. NACK wins over a simultaneous ACK.
  - `ack_i` alone → COMMIT.
  - Bad verdict with `retry`==`MAX_RETRY` → FAIL; otherwise → REWIND.
  - `ack_i`/`nack_i` are ignored outside WAIT_ACK.
- **COMMIT**
  - `fifo_command_o`=1, `frame_done_o`=1.
  - `retry` ← 0; → IDLE.
- **REWIND**
  - `fifo_command_o`=2.
  - `retry` ← `retry`+1, `word_cnt` ← 0; → SEND.
- **FAIL**
  - `fifo_command_o`=1, which discards the frame and frees FIFO space. `frame_fail_o`=1.
  - `retry` ← 0; → IDLE.
- **Outputs**
  - `fifo_command_o`, `frame_done_o`, `frame_fail_o` and `busy_o` are Moore decodes of the state register.
  - `retry_cnt_o` = `retry`.
- **Reset** (also mid-frame)
  - State → IDLE, all counters 0.
  - Every output is 0 in the cycle after `reset` is sampled high; `fifo_command_o`=0.
  - No commit or rewind is issued for a partially sent frame.

## Timing
- `start_i` at cycle t → SEND at t+1. First `rd_en_fast_o` at t+1 if the FIFO is not empty.
- An unstalled frame occupies `FRAME_LEN` consecutive cycles; the last word is at t+`FRAME_LEN`.
- WAIT_ACK is entered the cycle after the last word.
- `ack_i` at cycle a → COMMIT at a+1 with command 1 → IDLE at a+2. Earliest next `start_i` acceptance is a+2.
- No response: the implicit NACK takes effect in the `ACK_TIMEOUT`-th WAIT_ACK cycle, and REWIND or FAIL follows the next cycle.
- REWIND lasts one cycle. The FIFO read pointer is restored at the end of that cycle, so the first retransmitted read is the cycle after REWIND. This is safe because `rd_en_fast_o`=0 during REWIND.
- Worst-case frame lifetime: (`MAX_RETRY`+1)×(`FRAME_LEN`+`ACK_TIMEOUT`+1)+1 cycles, excluding stalls.

## Test plan
- **Clean frame** — `FRAME_LEN`=4, FIFO holds 4 words, `start_i` pulse, `ack_i` 3 cycles after the last word:
  - 4 consecutive `rd_en_fast_o`, `frame_last_o` on the 4th;
  - `fifo_command_o`=1 for exactly one cycle; `frame_done_o` pulse; `busy_o` low after.
- **Single NACK** — `nack_i` in the 1st WAIT_ACK cycle:
  - `fifo_command_o`=2 for one cycle, `retry_cnt_o`=1;
  - 4 reads repeat the same data words; then `ack_i` → command 1, `retry_cnt_o` back to 0.
- **Timeout exhaustion** — `ACK_TIMEOUT`=8, `MAX_RETRY`=2, never ACK:
  - 3 transmissions, each separated by 8 WAIT_ACK cycles;
  - 2 rewinds, then `frame_fail_o` with `fifo_command_o`=1.
- **Underflow stall** — FIFO holds 2 words, 2 more written 5 cycles later:
  - `rd_en_fast_o` gaps while empty, `word_cnt` holds;
  - `frame_last_o` on the 4th read; no timeout during the stall.
- **Simultaneous ACK+NACK** — both in the same WAIT_ACK cycle:
  - REWIND taken, `fifo_command_o`=2.
- **Mid-frame reset** — `reset` asserted after 2 reads:
  - next cycle all outputs 0 and `fifo_command_o`=0;
  - a fresh `start_i` restarts with `word_cnt`=0.
